// File: rtl/fifo_seq_reader_pkg.sv
// -----------------------------------------------------------------------------
// fifo_seq_reader_pkg
// Shared types and helpers for the FIFO sequence reader:
//   - rd_state_e : reader FSM state encoding
//   - sat_inc    : saturating increment for counters up to 64 bits wide
// -----------------------------------------------------------------------------
package fifo_seq_reader_pkg;

  // Reader FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEED = 2'd1,
    ST_RUN  = 2'd2,
    ST_HALT = 2'd3
  } rd_state_e;

  // Increment value, holding at the all-ones value of the given width
  function automatic logic [63:0] sat_inc(input logic [63:0] value,
                                          input int unsigned width);
    logic [63:0] max_val;
    max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (value >= max_val) ? value : value + 64'd1;
  endfunction

endpackage

// File: rtl/fifo_out_reg.sv
// -----------------------------------------------------------------------------
// fifo_out_reg
// Single-entry valid/ready output register. A load captures din and raises
// valid; an accept without a load drops valid. Load and accept together keep
// valid high with the new word, so throughput is one word per cycle.
// Ports:
//   rclk, rrst_n : clock, asynchronous active-low reset
//   load         : capture din this edge
//   din          : word to capture
//   ready        : downstream accepts dout
//   dout, valid  : registered word and its valid flag
// -----------------------------------------------------------------------------
module fifo_out_reg #(
  parameter int unsigned DW = 8
) (
  input  logic          rclk,
  input  logic          rrst_n,
  input  logic          load,
  input  logic [DW-1:0] din,
  input  logic          ready,
  output logic [DW-1:0] dout,
  output logic          valid
);

  // Output holding register
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      dout  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      dout  <= din;
      valid <= 1'b1;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_seq_reader.sv
// -----------------------------------------------------------------------------
// fifo_seq_reader
// Read-domain consumer for async_fifo. Pops FWFT words while enabled and the
// output register can take them, re-presents them on a valid/ready stream and
// checks that they form a contiguous incrementing sequence (mod 2^DW).
// Ports:
//   rclk, rrst_n   : read clock, asynchronous active-low reset
//   en             : enable popping
//   clr            : clear counters/sticky error, return to seeding
//   renable, rdata : FIFO not-empty flag and head word
//   rinc           : pop strobe (combinational)
//   dout, dout_valid, dout_ready : output stream
//   exp_data       : next expected word
//   rd_count       : popped words (saturating)
//   err_count      : mismatches (saturating)
//   err_sticky     : mismatch seen since reset/clr
//   bad_data       : word captured at the latest mismatch
// -----------------------------------------------------------------------------
module fifo_seq_reader
  import fifo_seq_reader_pkg::*;
#(
  parameter int unsigned   DW          = 8,
  parameter int unsigned   CW          = 16,
  parameter bit            SEED_FIRST  = 1'b1,
  parameter logic [DW-1:0] INIT_VAL    = '0,
  parameter bit            STOP_ON_ERR = 1'b0
) (
  input  logic          rclk,
  input  logic          rrst_n,
  input  logic          en,
  input  logic          clr,
  input  logic          renable,
  input  logic [DW-1:0] rdata,
  output logic          rinc,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic [DW-1:0] exp_data,
  output logic [CW-1:0] rd_count,
  output logic [CW-1:0] err_count,
  output logic          err_sticky,
  output logic [DW-1:0] bad_data
);

  rd_state_e     state_q,  state_d;
  logic          seeded_q, seeded_d;
  logic [DW-1:0] exp_q,    exp_d;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d;
  logic [CW-1:0] err_cnt_q, err_cnt_d;
  logic          sticky_q, sticky_d;
  logic [DW-1:0] bad_q,    bad_d;

  logic          active;
  logic          pop;
  logic          match;

  // Pop only in SEED/RUN, with data present, room downstream and no clr
  assign active = (state_q == ST_SEED) || (state_q == ST_RUN);
  assign pop    = renable & en & ~clr & active & (~dout_valid | dout_ready);
  assign rinc   = pop;
  assign match  = (rdata == exp_q);

  // Output register
  fifo_out_reg #(
    .DW (DW)
  ) u_out_reg (
    .rclk   (rclk),
    .rrst_n (rrst_n),
    .load   (pop),
    .din    (rdata),
    .ready  (dout_ready),
    .dout   (dout),
    .valid  (dout_valid)
  );

  // State and checker registers
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q   <= ST_IDLE;
      seeded_q  <= 1'b0;
      exp_q     <= INIT_VAL;
      rd_cnt_q  <= '0;
      err_cnt_q <= '0;
      sticky_q  <= 1'b0;
      bad_q     <= '0;
    end else begin
      state_q   <= state_d;
      seeded_q  <= seeded_d;
      exp_q     <= exp_d;
      rd_cnt_q  <= rd_cnt_d;
      err_cnt_q <= err_cnt_d;
      sticky_q  <= sticky_d;
      bad_q     <= bad_d;
    end
  end

  // Next-state and checker update
  always_comb begin
    state_d   = state_q;
    seeded_d  = seeded_q;
    exp_d     = exp_q;
    rd_cnt_d  = rd_cnt_q;
    err_cnt_d = err_cnt_q;
    sticky_d  = sticky_q;
    bad_d     = bad_q;

    if (clr) begin
      // clr wins over everything; any pop this cycle is already masked
      state_d   = ST_IDLE;
      seeded_d  = 1'b0;
      exp_d     = INIT_VAL;
      rd_cnt_d  = '0;
      err_cnt_d = '0;
      sticky_d  = 1'b0;
      bad_d     = '0;
    end else if (!en) begin
      // Pause: counters, expectation and seeded flag are retained
      state_d = ST_IDLE;
    end else begin
      if (pop) begin
        rd_cnt_d = CW'(sat_inc(64'(rd_cnt_q), CW));
      end

      unique case (state_q)
        ST_IDLE: begin
          state_d = (SEED_FIRST && !seeded_q) ? ST_SEED : ST_RUN;
        end

        ST_SEED: begin
          if (pop) begin
            exp_d    = rdata + DW'(1);
            seeded_d = 1'b1;
            state_d  = ST_RUN;
          end
        end

        ST_RUN: begin
          if (pop) begin
            if (match) begin
              exp_d = exp_q + DW'(1);
            end else begin
              // Resynchronise on the bad word so one glitch counts once
              err_cnt_d = CW'(sat_inc(64'(err_cnt_q), CW));
              sticky_d  = 1'b1;
              bad_d     = rdata;
              exp_d     = rdata + DW'(1);
              if (STOP_ON_ERR) begin
                state_d = ST_HALT;
              end
            end
          end
        end

        ST_HALT: begin
          state_d = ST_HALT;
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign exp_data   = exp_q;
  assign rd_count   = rd_cnt_q;
  assign err_count  = err_cnt_q;
  assign err_sticky = sticky_q;
  assign bad_data   = bad_q;

endmodule

// File: tb/tb_fifo_seq_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_seq_reader
// Bench for fifo_seq_reader: a queue models the FWFT FIFO, and each popped
// word is pushed to a scoreboard and compared when dout is accepted.
// A second instance with STOP_ON_ERR=1 covers the halt behaviour.
// -----------------------------------------------------------------------------
module tb_fifo_seq_reader;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 16;

  logic          rclk = 1'b0;
  logic          rrst_n;
  logic          en, clr, renable, dout_ready;
  logic [DW-1:0] rdata;
  logic          rinc, dout_valid, err_sticky;
  logic [DW-1:0] dout, exp_data, bad_data;
  logic [CW-1:0] rd_count, err_count;

  logic          h_en, h_clr, h_renable, h_dout_ready;
  logic [DW-1:0] h_rdata;
  logic          h_rinc, h_dout_valid, h_sticky;
  logic [DW-1:0] h_dout, h_exp, h_bad;
  logic [CW-1:0] h_rd, h_err;

  always #5 rclk = ~rclk;

  fifo_seq_reader #(.DW(DW), .CW(CW), .SEED_FIRST(1'b1), .INIT_VAL('0),
                    .STOP_ON_ERR(1'b0)) u_dut (
    .rclk(rclk), .rrst_n(rrst_n), .en(en), .clr(clr),
    .renable(renable), .rdata(rdata), .rinc(rinc),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .exp_data(exp_data), .rd_count(rd_count), .err_count(err_count),
    .err_sticky(err_sticky), .bad_data(bad_data)
  );

  fifo_seq_reader #(.DW(DW), .CW(CW), .SEED_FIRST(1'b1), .INIT_VAL('0),
                    .STOP_ON_ERR(1'b1)) u_halt (
    .rclk(rclk), .rrst_n(rrst_n), .en(h_en), .clr(h_clr),
    .renable(h_renable), .rdata(h_rdata), .rinc(h_rinc),
    .dout(h_dout), .dout_valid(h_dout_valid), .dout_ready(h_dout_ready),
    .exp_data(h_exp), .rd_count(h_rd), .err_count(h_err),
    .err_sticky(h_sticky), .bad_data(h_bad)
  );

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] sb_q[$];
  logic [DW-1:0] hw [4];
  int n_checks = 0;
  int n_errors = 0;
  int pops, accepts, cyc, first_pop, last_pop, hidx;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present the FIFO head to the DUT
  task automatic refresh();
    renable = (fifo_q.size() != 0);
    rdata   = renable ? fifo_q[0] : '0;
  endtask

  // One cycle of the main DUT, entered and left at a falling edge
  task automatic tick();
    logic p;
    logic [DW-1:0] w;
    refresh();
    #2;
    p = rinc;
    if (clr)      check("rinc_during_clr", 32'(rinc), 0);
    if (!renable) check("rinc_when_empty", 32'(rinc), 0);
    if (dout_valid && dout_ready) begin
      check("sb_nonempty", 32'(sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        w = sb_q.pop_front();
        check("dout", 32'(dout), 32'(w));
      end
      accepts++;
    end
    @(posedge rclk);
    if (p && fifo_q.size() != 0) begin
      sb_q.push_back(fifo_q.pop_front());
      pops++;
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
    end
    cyc++;
    @(negedge rclk);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((fifo_q.size() != 0 || dout_valid) && g < 40) begin
      tick();
      g++;
    end
    check("drain_bound", 32'(g < 40), 1);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic push4(input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [DW-1:0] c, input logic [DW-1:0] d);
    fifo_q.push_back(a);
    fifo_q.push_back(b);
    fifo_q.push_back(c);
    fifo_q.push_back(d);
  endtask

  // One cycle of the halting instance
  task automatic h_step();
    logic p;
    h_renable = (hidx < 4);
    h_rdata   = (hidx < 4) ? hw[hidx] : '0;
    #2;
    p = h_rinc;
    @(posedge rclk);
    if (p) hidx++;
    @(negedge rclk);
  endtask

  initial begin
    rrst_n = 1'b0; en = 1'b0; clr = 1'b0; dout_ready = 1'b0;
    renable = 1'b0; rdata = '0;
    h_en = 1'b0; h_clr = 1'b0; h_renable = 1'b0; h_dout_ready = 1'b1;
    h_rdata = '0;
    pops = 0; accepts = 0; cyc = 0; first_pop = -1; last_pop = -1; hidx = 0;
    hw[0] = 8'd10; hw[1] = 8'd11; hw[2] = 8'd13; hw[3] = 8'd14;
    repeat (3) @(negedge rclk);

    // Reset values
    check("rst_rinc",       32'(rinc), 0);
    check("rst_dout_valid", 32'(dout_valid), 0);
    check("rst_rd_count",   32'(rd_count), 0);
    check("rst_err_count",  32'(err_count), 0);
    check("rst_exp_data",   32'(exp_data), 0);
    check("rst_bad_data",   32'(bad_data), 0);
    rrst_n = 1'b1;
    @(negedge rclk);

    // 1: seeded run 5..8
    dout_ready = 1'b1;
    push4(8'd5, 8'd6, 8'd7, 8'd8);
    en = 1'b1;
    drain();
    check("t1_pops",        32'(pops), 4);
    check("t1_consecutive", 32'(last_pop - first_pop), 3);
    check("t1_rd_count",    32'(rd_count), 4);
    check("t1_err_count",   32'(err_count), 0);
    check("t1_exp_data",    32'(exp_data), 9);

    // 2: wrap-around FE,FF,00,01
    pulse_clr();
    check("clr_rd_count",  32'(rd_count), 0);
    check("clr_exp_data",  32'(exp_data), 0);
    push4(8'hFE, 8'hFF, 8'h00, 8'h01);
    drain();
    check("t2_err_count",  32'(err_count), 0);
    check("t2_exp_data",   32'(exp_data), 32'h02);
    check("t2_rd_count",   32'(rd_count), 4);

    // 3: gap 10,11,13,14 without halting
    pulse_clr();
    push4(8'd10, 8'd11, 8'd13, 8'd14);
    drain();
    check("t3_err_count",  32'(err_count), 1);
    check("t3_bad_data",   32'(bad_data), 13);
    check("t3_err_sticky", 32'(err_sticky), 1);
    check("t3_rd_count",   32'(rd_count), 4);
    check("t3_exp_data",   32'(exp_data), 15);

    // 4: same gap with STOP_ON_ERR=1
    h_en = 1'b1;
    for (int c = 0; c < 10; c++) h_step();
    check("t4_popped_to_13", 32'(hidx), 3);
    check("t4_err_count",    32'(h_err), 1);
    check("t4_bad_data",     32'(h_bad), 13);
    h_renable = 1'b1;
    h_rdata   = hw[3];
    #1;
    check("t4_halt_rinc",    32'(h_rinc), 0);
    @(negedge rclk);
    h_en = 1'b0;
    h_step();
    h_en = 1'b1;
    repeat (4) h_step();
    check("t4_resume_pop",   32'(hidx), 4);
    check("t4_err_after",    32'(h_err), 1);
    check("t4_rd_count",     32'(h_rd), 4);
    check("t4_dout",         32'(h_dout), 14);
    check("t4_exp_data",     32'(h_exp), 15);

    // 5: backpressure
    pulse_clr();
    dout_ready = 1'b0;
    for (int i = 20; i < 26; i++) fifo_q.push_back(DW'(i));
    pops = 0;
    repeat (5) tick();
    check("t5_single_pop",   32'(pops), 1);
    check("t5_dout_valid",   32'(dout_valid), 1);
    refresh();
    #1;
    check("t5_rinc_stalled", 32'(rinc), 0);
    @(negedge rclk);
    dout_ready = 1'b1;
    accepts = 0;
    drain();
    check("t5_accepts",      32'(accepts), 6);
    check("t5_sb_empty",     32'(sb_q.size()), 0);
    check("t5_err_count",    32'(err_count), 0);
    check("t5_rd_count",     32'(rd_count), 6);

    // 6: asynchronous reset mid-stream, then clr with data present
    for (int i = 30; i < 40; i++) fifo_q.push_back(DW'(i));
    repeat (4) tick();
    #1;
    rrst_n = 1'b0;
    #1;
    check("t6_rst_rinc",       32'(rinc), 0);
    check("t6_rst_dout_valid", 32'(dout_valid), 0);
    check("t6_rst_rd_count",   32'(rd_count), 0);
    fifo_q.delete();
    sb_q.delete();
    @(negedge rclk);
    rrst_n = 1'b1;
    fifo_q.push_back(8'd40);
    fifo_q.push_back(8'd41);
    fifo_q.push_back(8'd50);
    drain();
    check("t6_sticky_set",  32'(err_sticky), 1);
    fifo_q.push_back(8'd51);
    pops = 0;
    pulse_clr();
    check("t6_clr_no_pop",  32'(pops), 0);
    check("t6_fifo_kept",   32'(fifo_q.size()), 1);
    check("t6_clr_sticky",  32'(err_sticky), 0);
    check("t6_clr_rd",      32'(rd_count), 0);
    drain();
    check("t6_reseed_rd",   32'(rd_count), 1);
    check("t6_reseed_err",  32'(err_count), 0);
    check("t6_reseed_exp",  32'(exp_data), 52);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
